multicycle_control: RTL and testbench

//  Main control FSM for the multi-cycle RV32I core. It decodes the latched IR opcode and sequences

---
 rtl/multicycle_control_pkg.sv | 68 ++++++
 rtl/multicycle_control_wait_timer.sv | 30 +++
 rtl/multicycle_control.sv | 168 ++++++++++++++++
 tb/tb_multicycle_control.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Purpose: shared encodings for the multi-cycle RV32I control path (states, opcodes, selects).
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_ADDR,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB_ALU,
    ST_WB_MEM,
    ST_BRANCH,
    ST_JAL,
    ST_JALR,
    ST_LUI,
    ST_AUIPC
  } state_t;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_SRC_A_PC    = 2'b00;
  localparam logic [1:0] ALU_SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] ALU_SRC_A_RS1   = 2'b10;

  localparam logic [1:0] ALU_SRC_B_RS2  = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MDR = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC  = 2'b10;
  localparam logic [1:0] MEM_TO_REG_IMM = 2'b11;

  // DECODE successor; ST_FETCH doubles as the "unknown opcode" answer.
  function automatic state_t decode_next(input logic [6:0] opcode);
    case (opcode)
      OP_R:      return ST_EXEC_R;
      OP_I:      return ST_EXEC_I;
      OP_LOAD:   return ST_ADDR;
      OP_STORE:  return ST_ADDR;
      OP_BRANCH: return ST_BRANCH;
      OP_JAL:    return ST_JAL;
      OP_JALR:   return ST_JALR;
      OP_LUI:    return ST_LUI;
      OP_AUIPC:  return ST_AUIPC;
      default:   return ST_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// Purpose: counts cycles spent waiting on memory; flags when the wait budget is used up.
// Latency: timeout is combinational from the count register; count updates on the next edge.
// Backpressure: none; clear has priority over enable.
// Ports: clk, reset (async, active-high), clear, en -> timeout.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic timeout
);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (en) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout = (wait_cnt == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control.sv
// Purpose: main control FSM of the multi-cycle RV32I core, one state per cycle.
// Latency: outputs decoded combinationally from the current state (mem_ready/opcode qualify a few).
// Backpressure: FETCH/MEM_RD/MEM_WR hold their request until mem_ready or a wait timeout.
// Ports: clk, reset, opcode, branch_taken, mem_ready -> memory request, mux selects,
//        write enables, alu_op, illegal_instr / mem_fault / instr_retired pulses.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       illegal_instr,
  output logic       mem_fault,
  output logic       instr_retired
);

  state_t state, state_nxt;
  logic   in_mem, tmo, fault;

  // branch_taken is consumed by the datapath through pc_write_cond, not by sequencing.
  logic unused_ok;
  assign unused_ok = branch_taken;

  assign in_mem = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);
  assign fault  = in_mem && tmo && !mem_ready;

  // Clearing on any state change or on a fault makes a FETCH->FETCH retry start a fresh budget.
  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state_nxt != state) || fault),
    .en      (in_mem && !mem_ready),
    .timeout (tmo)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:  if (mem_ready) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = decode_next(opcode);
      ST_EXEC_R, ST_EXEC_I, ST_AUIPC: state_nxt = ST_WB_ALU;
      ST_ADDR:   state_nxt = (opcode == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: if (mem_ready) state_nxt = ST_WB_MEM;
                 else if (fault) state_nxt = ST_FETCH;
      ST_MEM_WR: if (mem_ready || fault) state_nxt = ST_FETCH;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_nxt;
  end

  // Reset forces everything low so an in-flight request drops asynchronously.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = ALU_SRC_A_PC;
    alu_src_b     = ALU_SRC_B_RS2;
    alu_op        = ALUOP_ADD;
    reg_write     = 1'b0;
    mem_to_reg    = MEM_TO_REG_ALU;
    illegal_instr = 1'b0;
    mem_fault     = 1'b0;
    instr_retired = 1'b0;
    if (!reset) begin
      mem_fault = fault;
      case (state)
        ST_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = ALU_SRC_B_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        ST_DECODE: begin
          alu_src_a     = ALU_SRC_A_OLDPC;
          alu_src_b     = ALU_SRC_B_IMM;
          illegal_instr = (decode_next(opcode) == ST_FETCH);
        end
        ST_EXEC_R: begin
          alu_src_a = ALU_SRC_A_RS1;
          alu_op    = ALUOP_RTYPE;
        end
        ST_EXEC_I: begin
          alu_src_a = ALU_SRC_A_RS1;
          alu_src_b = ALU_SRC_B_IMM;
          alu_op    = ALUOP_ITYPE;
        end
        ST_AUIPC: begin
          alu_src_a = ALU_SRC_A_OLDPC;
          alu_src_b = ALU_SRC_B_IMM;
        end
        ST_ADDR, ST_JALR: begin
          alu_src_a = ALU_SRC_A_RS1;
          alu_src_b = ALU_SRC_B_IMM;
          if (state == ST_JALR) begin
            reg_write     = 1'b1;
            mem_to_reg    = MEM_TO_REG_PC;
            pc_write      = 1'b1;
            instr_retired = 1'b1;
          end
        end
        ST_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        ST_MEM_WR: begin
          mem_write     = 1'b1;
          iord          = 1'b1;
          instr_retired = mem_ready;
        end
        ST_WB_ALU: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
        ST_WB_MEM: begin
          reg_write     = 1'b1;
          mem_to_reg    = MEM_TO_REG_MDR;
          instr_retired = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a     = ALU_SRC_A_RS1;
          alu_op        = ALUOP_SUB;
          pc_write_cond = 1'b1;
          pc_src        = 1'b1;
          instr_retired = 1'b1;
        end
        ST_JAL: begin
          reg_write     = 1'b1;
          mem_to_reg    = MEM_TO_REG_PC;
          pc_write      = 1'b1;
          pc_src        = 1'b1;
          instr_retired = 1'b1;
        end
        ST_LUI: begin
          reg_write     = 1'b1;
          mem_to_reg    = MEM_TO_REG_IMM;
          instr_retired = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int TO = 4;

  typedef struct packed {
    logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       illegal_instr, mem_fault, instr_retired;
  } out_t;

  typedef struct {
    logic [6:0] opcode;
    logic       bt;
    logic       rdy;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op, mem_to_reg;
  logic       reg_write, illegal_instr, mem_fault, instr_retired;
  out_t       dut_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  vec_t q[$];
  int ret_q[$];
  int flt_q[$];
  int ill_q[$];

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal_instr(illegal_instr),
    .mem_fault(mem_fault), .instr_retired(instr_retired)
  );

  assign dut_o = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
                  illegal_instr, mem_fault, instr_retired};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic push(input logic [6:0] opc, input logic bt, input logic rdy, input out_t e);
    vec_t v;
    v.opcode = opc; v.bt = bt; v.rdy = rdy; v.exp = e;
    q.push_back(v);
  endtask

  // A memory wait: 'waits' cycles without ready, then one with ready, unless the
  // budget of TO idle cycles runs out first (fault on the idle cycle numbered TO).
  task automatic mem_phase(input logic [6:0] opc, input logic bt, input int waits,
                           input bit is_fetch, input bit is_write, output bit ok);
    out_t e;
    ok = 1'b0;
    for (int k = 0; k <= TO; k++) begin
      e = '0;
      e.mem_read  = !is_write;
      e.mem_write = is_write;
      e.iord      = !is_fetch;
      if (is_fetch) e.alu_src_b = 2'b01;
      if (k < waits) begin
        e.mem_fault = (k == TO);
        push(opc, bt, 1'b0, e);
        if (k == TO) return;
      end else begin
        e.ir_write      = is_fetch;
        e.pc_write      = is_fetch;
        e.instr_retired = is_write;
        push(opc, bt, 1'b1, e);
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Expected cycle-by-cycle outputs of one whole instruction.
  task automatic instr(input logic [6:0] opc, input logic bt, input int fwait,
                       input int mwait, input logic idle);
    out_t e;
    bit   ok;
    mem_phase(opc, bt, fwait, 1'b1, 1'b0, ok);
    if (!ok) return;
    e = '0;
    e.alu_src_a = 2'b01;
    e.alu_src_b = 2'b10;
    e.illegal_instr = !(opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                    7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                    7'b0010111});
    push(opc, bt, idle, e);
    if (e.illegal_instr) return;
    e = '0;
    case (opc)
      7'b0110011, 7'b0010011, 7'b0010111: begin
        e.alu_src_a = (opc == 7'b0010111) ? 2'b01 : 2'b10;
        e.alu_src_b = (opc == 7'b0110011) ? 2'b00 : 2'b10;
        e.alu_op    = (opc == 7'b0110011) ? 2'b10 : (opc == 7'b0010011) ? 2'b11 : 2'b00;
        push(opc, bt, idle, e);
        e = '0; e.reg_write = 1'b1; e.instr_retired = 1'b1;
        push(opc, bt, idle, e);
      end
      7'b0000011, 7'b0100011: begin
        e.alu_src_a = 2'b10; e.alu_src_b = 2'b10;
        push(opc, bt, idle, e);
        mem_phase(opc, bt, mwait, 1'b0, opc == 7'b0100011, ok);
        if (ok && opc == 7'b0000011) begin
          e = '0; e.reg_write = 1'b1; e.mem_to_reg = 2'b01; e.instr_retired = 1'b1;
          push(opc, bt, idle, e);
        end
      end
      7'b1100011: begin
        e.alu_src_a = 2'b10; e.alu_op = 2'b01; e.pc_write_cond = 1'b1;
        e.pc_src = 1'b1; e.instr_retired = 1'b1;
        push(opc, bt, idle, e);
      end
      7'b1101111, 7'b1100111: begin
        if (opc == 7'b1100111) begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b10; end
        e.reg_write = 1'b1; e.mem_to_reg = 2'b10; e.pc_write = 1'b1;
        e.pc_src = (opc == 7'b1101111); e.instr_retired = 1'b1;
        push(opc, bt, idle, e);
      end
      default: begin
        e.reg_write = 1'b1; e.mem_to_reg = 2'b11; e.instr_retired = 1'b1;
        push(opc, bt, idle, e);
      end
    endcase
  endtask

  task automatic run(input int n);
    vec_t v;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      v = q.pop_front();
      @(negedge clk);
      reset = 1'b0;
      opcode = v.opcode; branch_taken = v.bt; mem_ready = v.rdy;
      #1;
      cyc++;
      chk($sformatf("cyc%0d_outputs", cyc), {11'b0, dut_o}, {11'b0, v.exp});
      if (instr_retired) ret_q.push_back(cyc);
      if (mem_fault)     flt_q.push_back(cyc);
      if (illegal_instr) ill_q.push_back(cyc);
    end
  endtask

  initial begin
    int   exp_ret[11];
    int   nret;
    out_t fetch_idle;
    exp_ret = '{4, 12, 15, 18, 26, 30, 33, 36, 39, 43, 52};

    @(negedge clk); #1;
    chk("reset_outputs", {11'b0, dut_o}, 32'd0);

    instr(7'b0110011, 1'b0, 0, 0, 1'b1);   // add
    instr(7'b0000011, 1'b0, 0, 3, 1'b1);   // lw, 3 wait cycles
    instr(7'b1100011, 1'b1, 0, 0, 1'b0);   // beq taken
    instr(7'b1100011, 1'b0, 0, 0, 1'b1);   // beq not taken
    instr(7'b1111111, 1'b0, 0, 0, 1'b1);   // illegal
    instr(7'b0100011, 1'b0, 2, 0, 1'b0);   // sw, slow fetch
    instr(7'b0010011, 1'b0, 0, 0, 1'b1);   // addi
    instr(7'b1101111, 1'b0, 0, 0, 1'b0);   // jal
    instr(7'b1100111, 1'b0, 0, 0, 1'b1);   // jalr
    instr(7'b0110111, 1'b0, 0, 0, 1'b1);   // lui
    instr(7'b0010111, 1'b0, 0, 0, 1'b0);   // auipc
    instr(7'b0110011, 1'b0, 99, 0, 1'b1);  // fetch never answered
    instr(7'b0110011, 1'b0, 0, 0, 1'b0);   // re-fetch succeeds
    instr(7'b0000011, 1'b0, 0, 99, 1'b1);  // load never answered
    run(q.size());

    chk("retire_count", ret_q.size(), 32'd11);
    for (int i = 0; i < 11; i++)
      chk($sformatf("retire_cycle_%0d", i), (i < ret_q.size()) ? ret_q[i] : -1, exp_ret[i]);
    chk("fault_count", flt_q.size(), 32'd2);
    chk("fault_cycle_0", (flt_q.size() > 0) ? flt_q[0] : -1, 32'd48);
    chk("fault_cycle_1", (flt_q.size() > 1) ? flt_q[1] : -1, 32'd60);
    chk("illegal_count", ill_q.size(), 32'd1);
    chk("illegal_cycle", (ill_q.size() > 0) ? ill_q[0] : -1, 32'd20);

    // Store stalled in MEM_WR, then reset lands mid-cycle.
    q.delete();
    instr(7'b0100011, 1'b0, 0, 99, 1'b1);
    run(4);
    chk("mem_wr_before_reset", mem_write, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_mem_write", mem_write, 1'b0);
    chk("rst_async_outputs", {11'b0, dut_o}, 32'd0);
    @(negedge clk); #1;
    chk("rst_held_outputs", {11'b0, dut_o}, 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    fetch_idle = '0;
    fetch_idle.mem_read  = 1'b1;
    fetch_idle.alu_src_b = 2'b01;
    chk("post_reset_fetch", {11'b0, dut_o}, {11'b0, fetch_idle});

    q.delete();
    nret = ret_q.size();
    instr(7'b0110011, 1'b0, 0, 0, 1'b1);
    run(q.size());
    chk("post_reset_retire", ret_q.size(), nret + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
